// File: rtl/fft_bfly_sched.sv
// fft_bfly_sched: stage/butterfly sequencer for an in-place radix-2 DIF FFT.
// Drives a sync-read RAM (1-cycle latency) and a two-cycle sum/diff butterfly unit.
// Optional stall input enabled by defining FFT_BFLY_SCHED_HOLD_EN.
module fft_bfly_sched #(
  parameter  int DATA_FFT_SIZE   = 16,
  parameter  int FFT_POINTS_LOG2 = 3,
  localparam int L               = FFT_POINTS_LOG2,
  localparam int SW              = (FFT_POINTS_LOG2 > 1) ? $clog2(FFT_POINTS_LOG2) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef FFT_BFLY_SCHED_HOLD_EN
  input  logic          hold,
`endif
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] stage,
  output logic          stage_done,
  output logic          rd_valid,
  output logic [L-1:0]  rd_addr0,
  output logic [L-1:0]  rd_addr1,
  output logic          bf_en,
  output logic [L-2:0]  tw_idx,
  output logic          wr_en,
  output logic [L-1:0]  wr_addr0,
  output logic [L-1:0]  wr_addr1
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [L-1:0]  ONE   = L'(1);
  localparam logic [L-1:0]  HALF  = ONE << (L - 1);
  localparam logic [L-2:0]  KLAST = '1;
  localparam logic [SW-1:0] SLAST = SW'(L - 1);

  generate
    if (FFT_POINTS_LOG2 < 2) begin : g_bad_points
      $error("fft_bfly_sched: FFT_POINTS_LOG2 must be >= 2");
    end
    if (DATA_FFT_SIZE < 1) begin : g_bad_width
      $error("fft_bfly_sched: DATA_FFT_SIZE must be >= 1");
    end
  endgenerate

  state_t           r_state, w_state_nxt;
  logic [L-2:0]     r_k;           // butterfly index within stage
  logic             r_ph;          // 0: first read cycle of a pair, 1: second
  logic [SW-1:0]    r_stage;
  logic             r_stage_done;
  logic [3:1]       r_vld_pipe;    // pair launch -> write-back (3 cycles)
  logic [3:1][L-1:0] r_wa0, r_wa1;
  logic             r_bf_en;
  logic [L-2:0]     r_tw;

  logic             w_hold, w_rd, w_issue, w_stage_end;
  logic [L-1:0]     w_span, w_mask, w_k, w_a0, w_a1;
  logic [L-2:0]     w_tw;

`ifdef FFT_BFLY_SCHED_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  // Hold only bites on the first cycle of a pair, so bf_en always comes in pairs.
  assign w_rd        = (r_state == S_RUN) && !(!r_ph && w_hold);
  assign w_issue     = w_rd && !r_ph;
  assign w_stage_end = (r_state == S_DRAIN) && r_vld_pipe[3];

  // Butterfly addressing: a0 is k with a 0 inserted at the span bit, a1 sets it.
  always_comb begin
    w_span = HALF >> r_stage;
    w_mask = w_span - ONE;
    w_k    = {1'b0, r_k};
    w_a0   = ((w_k & ~w_mask) << 1) | (w_k & w_mask);
    w_a1   = w_a0 | w_span;
    w_tw   = (r_k & w_mask[L-2:0]) << r_stage;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: drain waits for the stage's last write before the next stage reads.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_rd && r_ph && (r_k == KLAST)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_vld_pipe[3]) w_state_nxt = (r_stage == SLAST) ? S_DONE : S_RUN;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Butterfly / stage counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k          <= '0;
      r_ph         <= 1'b0;
      r_stage      <= '0;
      r_stage_done <= 1'b0;
    end else begin
      r_stage_done <= w_stage_end;
      if (r_state == S_IDLE) begin
        r_k  <= '0;
        r_ph <= 1'b0;
      end else if (w_rd) begin
        r_ph <= ~r_ph;
        if (r_ph) r_k <= r_k + (L-1)'(1);
      end
      if (w_stage_end) r_stage <= (r_stage == SLAST) ? '0 : r_stage + SW'(1);
    end
  end

  // Unit enable / twiddle follow reads by one cycle; write-back follows launch by three.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_wa0      <= '0;
      r_wa1      <= '0;
      r_bf_en    <= 1'b0;
      r_tw       <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[2:1], w_issue};
      r_wa0      <= {r_wa0[2:1], w_a0};
      r_wa1      <= {r_wa1[2:1], w_a1};
      r_bf_en    <= w_rd;
      if (w_issue) r_tw <= w_tw;
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign stage      = r_stage;
  assign stage_done = r_stage_done;
  assign rd_valid   = w_rd;
  assign rd_addr0   = w_rd ? w_a0 : '0;
  assign rd_addr1   = w_rd ? w_a1 : '0;
  assign bf_en      = r_bf_en;
  assign tw_idx     = r_bf_en ? r_tw : '0;
  assign wr_en      = r_vld_pipe[3];
  assign wr_addr0   = r_vld_pipe[3] ? r_wa0[3] : '0;
  assign wr_addr1   = r_vld_pipe[3] ? r_wa1[3] : '0;

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Bench for fft_bfly_sched: RAM + butterfly model, reference DFT, directed scenarios.
module tb_fft_bfly_sched;
  localparam int L  = 3;
  localparam int N  = 8;
  localparam int SW = 2;
  localparam real PI = 3.14159265358979323846;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
`ifdef FFT_BFLY_SCHED_HOLD_EN
  logic          hold = 1'b0;
`endif
  logic          busy, done, stage_done, rd_valid, bf_en, wr_en;
  logic [SW-1:0] stage;
  logic [L-1:0]  rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [L-2:0]  tw_idx;

  fft_bfly_sched #(.DATA_FFT_SIZE(16), .FFT_POINTS_LOG2(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef FFT_BFLY_SCHED_HOLD_EN
    .hold(hold),
`endif
    .busy(busy), .done(done), .stage(stage), .stage_done(stage_done),
    .rd_valid(rd_valid), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .bf_en(bf_en), .tw_idx(tw_idx), .wr_en(wr_en),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int a0; int a1; int s; } ev_t;
  ev_t rd_q[$], wr_q[$];
  int  tw_q[$];
  int  rd_ph, bf_ph, bf_cnt, hold_err, done_cnt, done_cyc, sd_cnt, first_rd, busy_at_done;
  int  p_a0, p_a1, p_tw;
  real re[N], im[N], xr[N], xi[N];
  real dr0, di0, dr1, di1, tr, ti, ang;
  real y0r[$], y0i[$], y1r[$], y1i[$];

  int n_chk = 0, n_pass = 0;

  // Observe the DUT: model RAM (read-old), butterfly unit, and log events.
  always @(negedge clk) begin
    if (bf_en) begin
      if (bf_ph == 0) begin
        tw_q.push_back(int'(tw_idx));
        ang = -2.0 * PI * real'(tw_idx) / real'(N);
        tr = dr0 - dr1; ti = di0 - di1;
        y0r.push_back(dr0 + dr1); y0i.push_back(di0 + di1);
        y1r.push_back(tr * $cos(ang) - ti * $sin(ang));
        y1i.push_back(tr * $sin(ang) + ti * $cos(ang));
      end else if (int'(tw_idx) != p_tw) hold_err++;
      p_tw = int'(tw_idx); bf_ph ^= 1; bf_cnt++;
    end
    if (rd_valid) begin
      if (rd_ph == 0) begin
        rd_q.push_back('{cyc, int'(rd_addr0), int'(rd_addr1), int'(stage)});
        if (first_rd < 0) first_rd = cyc;
      end else if (int'(rd_addr0) != p_a0 || int'(rd_addr1) != p_a1) hold_err++;
      p_a0 = int'(rd_addr0); p_a1 = int'(rd_addr1);
      dr0 = re[rd_addr0]; di0 = im[rd_addr0]; dr1 = re[rd_addr1]; di1 = im[rd_addr1];
      rd_ph ^= 1;
    end
    if (wr_en) begin
      wr_q.push_back('{cyc, int'(wr_addr0), int'(wr_addr1), int'(stage)});
      if (y0r.size() > 0) begin
        re[wr_addr0] = y0r.pop_front(); im[wr_addr0] = y0i.pop_front();
        re[wr_addr1] = y1r.pop_front(); im[wr_addr1] = y1i.pop_front();
      end
    end
    if (done) begin done_cnt++; done_cyc = cyc; if (busy) busy_at_done++; end
    if (stage_done) sd_cnt++;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_r(input string tag, input real obs, input real exp);
    real d;
    d = obs - exp; if (d < 0.0) d = -d;
    n_chk++;
    assert ((d < 1.0e-6) === 1'b1) n_pass++;
    else $error("FAIL %s: observed %f expected %f", tag, obs, exp);
  endtask

  task automatic mon_reset();
    rd_q.delete(); wr_q.delete(); tw_q.delete();
    y0r.delete(); y0i.delete(); y1r.delete(); y1i.delete();
    rd_ph = 0; bf_ph = 0; bf_cnt = 0; hold_err = 0; done_cnt = 0; done_cyc = -1;
    sd_cnt = 0; first_rd = -1; busy_at_done = 0;
    for (int i = 0; i < N; i++) begin
      xr[i] = real'($urandom_range(200)) - 100.0;
      xi[i] = real'($urandom_range(200)) - 100.0;
      re[i] = xr[i]; im[i] = xi[i];
    end
  endtask

  function automatic int bitrev(input int v);
    int r = 0;
    for (int b = 0; b < L; b++) if (v[b]) r |= 1 << (L - 1 - b);
    return r;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    @(negedge clk); #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {busy, done, stage_done, rd_valid, bf_en, wr_en, stage,
              rd_addr0, rd_addr1, tw_idx, wr_addr0, wr_addr1}, 0);
  endtask

  // Compare one logged transform against the addressing rule and a direct DFT.
  task automatic check_run(input int extra);
    int s, k, span, j, a0, m;
    real sr, si, an;
    chk("rd_pairs", rd_q.size(), L * N / 2);
    chk("wr_pairs", wr_q.size(), L * N / 2);
    chk("tw_count", tw_q.size(), L * N / 2);
    for (int i = 0; i < rd_q.size() && i < L * N / 2; i++) begin
      s = i / (N / 2); k = i % (N / 2); span = N >> (s + 1);
      j = k % span; a0 = (k / span) * 2 * span + j;
      chk("rd_a0", rd_q[i].a0, a0);
      chk("rd_a1", rd_q[i].a1, a0 + span);
      chk("rd_stage", rd_q[i].s, s);
      if (i < tw_q.size()) chk("tw_idx", tw_q[i], j << s);
      if (i < wr_q.size()) begin
        chk("wr_latency", wr_q[i].c - rd_q[i].c, 3);
        chk("wr_a0", wr_q[i].a0, rd_q[i].a0);
        chk("wr_a1", wr_q[i].a1, rd_q[i].a1);
      end
    end
    chk("done_latency", done_cyc - first_rd, L * (N + 2) + extra);
    chk("done_count", done_cnt, 1);
    chk("busy_at_done", busy_at_done, 1);
    chk("stage_done_count", sd_cnt, L);
    chk("bf_en_cycles", bf_cnt, L * N);
    chk("bf_en_paired", bf_ph, 0);
    chk("held_fields", hold_err, 0);
    for (m = 0; m < N; m++) begin
      sr = 0.0; si = 0.0;
      for (int n = 0; n < N; n++) begin
        an = -2.0 * PI * real'((n * m) % N) / real'(N);
        sr += xr[n] * $cos(an) - xi[n] * $sin(an);
        si += xr[n] * $sin(an) + xi[n] * $cos(an);
      end
      chk_r("fft_re", re[bitrev(m)], sr);
      chk_r("fft_im", im[bitrev(m)], si);
    end
  endtask

  initial begin
    mon_reset();
    // 1: reset and idle
    repeat (2) @(posedge clk);
    #1 chk_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("idle_busy", busy, 0);
      chk("idle_rd_valid", rd_valid, 0);
    end

    // 2/3: single-pulse full transform
    mon_reset();
    pulse_start();
    wait_done("run1");
    check_run(0);
    repeat (2) @(posedge clk);
    #1 chk("busy_after_done", busy, 0);

    // 4: start held high, re-pulsed mid-run; second run begins only after done
    mon_reset();
    @(posedge clk); #1 start = 1'b1;
    repeat (12) @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    wait_done("run_start_high");
    check_run(0);
    mon_reset();
    repeat (2) @(posedge clk);
    #1 chk("restart_busy", busy, 1);
    start = 1'b0;
    wait_done("run_restart");
    check_run(0);

    // 5: reset during stage 1 aborts, then a fresh run is complete
    mon_reset();
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (stage == 1 && rd_valid) break;
    end
    chk("reached_stage1", stage, 1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk_outputs_zero("async_abort");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", busy, 0);
    mon_reset();
    pulse_start();
    wait_done("run_after_abort");
    check_run(0);

`ifdef FFT_BFLY_SCHED_HOLD_EN
    // 6: stall after pair (1,5) for 5 cycles
    mon_reset();
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rd_valid && rd_addr0 == 1) break;
    end
    @(posedge clk); #1 hold = 1'b1;
    repeat (5) @(posedge clk);
    #1 hold = 1'b0;
    wait_done("run_hold");
    if (rd_q.size() > 2) chk("hold_issue_gap", rd_q[2].c - rd_q[1].c, 6);
    else chk("hold_issue_gap", rd_q.size(), 3);
    check_run(4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
